ex_stage_mdu: RTL

//  RV64 execute stage, fed directly by the ID->EX pipeline buffer outputs.

---
 rtl/ex_stage_mdu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: RV64 execute stage. Single-cycle integer ALU plus an iterative
// shift-add multiplier (MUL / MULHU) that stalls upstream for 65 cycles.
// Optional feature macro: EX_DIV_EN adds a restoring divider (DIVU / REMU)
// that shares the FSM, counter and product register with the multiplier.
module ex_stage_mdu #(
  parameter int N    = 32,
  parameter int LOGW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             flush,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       instrALUCtr,
  input  logic             mext,
  input  logic [N*2-1:0]   pc,
  input  logic [N*2-1:0]   data1,
  input  logic [N*2-1:0]   data2,
  input  logic [N*2-1:0]   immGen,
  output logic [N*2-1:0]   result,
  output logic             zero,
  output logic [N*2-1:0]   branch_target,
  output logic             valid_out,
  output logic             stall_out,
  output logic             busy
);
  localparam int W = N * 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} mop_t;

  state_t            state_reg, state_next;
  mop_t              mop_dec, mop_reg;
  logic              is_mdu;
  logic              start;
  logic              mop_div;
  logic [W-1:0]      op_b;
  logic [W-1:0]      alu_res;
  logic [W-1:0]      mdu_res;
  logic [2*W-1:0]    prod_reg, prod_next;
  logic [2*W-1:0]    a_reg;
  logic [W-1:0]      b_reg;
  logic [LOGW-1:0]   cnt_reg;
`ifdef EX_DIV_EN
  logic [W:0]        rem_sh;
  logic [W:0]        rem_diff;
`endif

  assign op_b          = ALUSrc ? immGen : data2;
  assign branch_target = pc + immGen;
  assign busy          = (state_reg != IDLE);
  assign mop_div       = (mop_reg == OP_DIVU) || (mop_reg == OP_REMU);
  assign mdu_res       = ((mop_reg == OP_MUL) || (mop_reg == OP_DIVU)) ?
                         prod_reg[W-1:0] : prod_reg[2*W-1:W];

  // Operation decode and single-cycle ALU result
  always_comb begin
    is_mdu  = 1'b0;
    mop_dec = OP_MUL;
    alu_res = '0;
    case (ALUOp)
      2'b01: alu_res = data1 - op_b;
      2'b10: begin
        if (mext && !ALUSrc) begin
          // M-extension: funct3 not handled by the MDU yields 0 in one cycle
          case (instrALUCtr[2:0])
            3'b000: begin is_mdu = 1'b1; mop_dec = OP_MUL;   end
            3'b011: begin is_mdu = 1'b1; mop_dec = OP_MULHU; end
`ifdef EX_DIV_EN
            3'b101: begin is_mdu = 1'b1; mop_dec = OP_DIVU;  end
            3'b111: begin is_mdu = 1'b1; mop_dec = OP_REMU;  end
`endif
            default: alu_res = '0;
          endcase
        end else begin
          case (instrALUCtr)
            4'b0000: alu_res = data1 + op_b;
            4'b1000: alu_res = ALUSrc ? (data1 + op_b) : (data1 - op_b);
            4'b0001: alu_res = data1 << op_b[LOGW-1:0];
            4'b0010: alu_res = {{(W-1){1'b0}}, $signed(data1) < $signed(op_b)};
            4'b0011: alu_res = {{(W-1){1'b0}}, data1 < op_b};
            4'b0100: alu_res = data1 ^ op_b;
            4'b0101: alu_res = data1 >> op_b[LOGW-1:0];
            4'b1101: alu_res = W'($signed(data1) >>> op_b[LOGW-1:0]);
            4'b0110: alu_res = data1 | op_b;
            4'b0111: alu_res = data1 & op_b;
            default: alu_res = '0;
          endcase
        end
      end
      default: alu_res = data1 + op_b;
    endcase
  end

  // Result / zero selection: MDU result while the FSM is active
  always_comb begin
    result = alu_res;
    zero   = (alu_res == '0);
    if (state_reg != IDLE || is_mdu) begin
      result = mdu_res;
      zero   = 1'b0;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    valid_out  = 1'b0;
    stall_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_mdu && valid_in && !flush) begin
          start      = 1'b1;
          stall_out  = 1'b1;
          state_next = BUSY;
        end else begin
          valid_out = valid_in & ~flush;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (cnt_reg == LOGW'(W - 1)) state_next = DONE;
      end
      DONE: begin
        valid_out  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      start      = 1'b0;
      valid_out  = 1'b0;
      stall_out  = 1'b0;
    end
    if (rst) begin
      start     = 1'b0;
      valid_out = 1'b0;
      stall_out = 1'b0;
    end
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    prod_next = prod_reg;
`ifdef EX_DIV_EN
    rem_sh   = prod_reg[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, b_reg};
    if (mop_div) begin
      // Divide by zero falls out naturally: all quotient bits set, remainder = dividend
      if (rem_sh >= {1'b0, b_reg})
        prod_next = {rem_diff[W-1:0], prod_reg[W-2:0], 1'b1};
      else
        prod_next = {rem_sh[W-1:0], prod_reg[W-2:0], 1'b0};
    end else
`endif
    if (b_reg[0]) begin
      prod_next = prod_reg + a_reg;
    end
  end

  // State, counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mop_reg   <= OP_MUL;
    end else begin
      state_reg <= state_next;
      if (start) begin
        mop_reg <= mop_dec;
        cnt_reg <= '0;
        b_reg   <= op_b;
        if ((mop_dec == OP_DIVU) || (mop_dec == OP_REMU)) begin
          prod_reg <= {{W{1'b0}}, data1};
          a_reg    <= '0;
        end else begin
          prod_reg <= '0;
          a_reg    <= {{W{1'b0}}, data1};
        end
      end else if (state_reg == BUSY) begin
        cnt_reg  <= cnt_reg + 1'b1;
        prod_reg <= prod_next;
        if (!mop_div) begin
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
        end
      end
    end
  end

endmodule
